// File: rtl/riscv_pkg.sv
// Types and constants shared across the core's memory path.
package riscv_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIfBusy,
        StDmBusy,
        StResp
    } arb_state_t;

    typedef struct packed {
        logic dm;
        logic fetch;
    } grant_t;

    localparam int unsigned DEFAULT_STARVE_LIMIT = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection: the data port wins unless the fetch port has been starved too long.
module mem_arb_pick
    import riscv_pkg::*;
(
    input  logic   if_req,
    input  logic   dm_req,
    input  logic   starve_hit,
    output grant_t grant
);

    always_comb begin
        grant = '0;
        if (dm_req && !(if_req && starve_hit)) begin
            grant.dm = 1'b1;
        end else if (if_req) begin
            grant.fetch = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the fetch and data ports onto one single-port memory, one access at a time.
module mem_arbiter
    import riscv_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    input  logic [3:0]  dm_be,
    output logic [31:0] dm_rdata,
    output logic        dm_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int unsigned CntW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    arb_state_t      state_q;
    logic [CntW-1:0] starve_cnt_q;
    logic            starve_hit;
    grant_t          grant;

    assign starve_hit = (starve_cnt_q == CntW'(STARVE_LIMIT));

    mem_arb_pick u_pick (
        .if_req     (if_req),
        .dm_req     (dm_req),
        .starve_hit (starve_hit),
        .grant      (grant)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            starve_cnt_q <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_be       <= '0;
            if_rdata     <= '0;
            dm_rdata     <= '0;
            if_ready     <= 1'b0;
            dm_ready     <= 1'b0;
        end else begin
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (grant.dm) begin
                        mem_req   <= 1'b1;
                        mem_we    <= dm_we;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        mem_be    <= dm_be;
                        state_q   <= StDmBusy;
                        if (if_req && !starve_hit) begin
                            starve_cnt_q <= starve_cnt_q + CntW'(1);
                        end
                    end else if (grant.fetch) begin
                        mem_req      <= 1'b1;
                        mem_we       <= 1'b0;
                        mem_addr     <= if_addr & 32'hFFFF_FFFC;
                        mem_wdata    <= '0;
                        mem_be       <= 4'hF;
                        starve_cnt_q <= '0;
                        state_q      <= StIfBusy;
                    end
                end
                StIfBusy: begin
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        if_rdata <= mem_rdata;
                        if_ready <= 1'b1;
                        state_q  <= StResp;
                    end
                end
                StDmBusy: begin
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        if (!mem_we) begin
                            dm_rdata <= mem_rdata;
                        end
                        dm_ready <= 1'b1;
                        state_q  <= StResp;
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // A requester must hold req while its access is in flight; the access completes anyway.
    if_req_held: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == StIfBusy) |-> if_req);
    dm_req_held: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == StDmBusy) |-> dm_req);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter against a small behavioural memory with programmable wait states.
module tb_mem_arbiter;
    import riscv_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    bit [31:0] mem_arr [0:255];
    int        wait_cfg;
    int        wait_cnt;
    logic      stray_ack;
    logic      mem_req_prev;
    bit        grants[$];
    int        n_checks;
    int        n_pass;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_be     (dm_be),
        .dm_rdata  (dm_rdata),
        .dm_ready  (dm_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory acks after wait_cfg extra cycles of mem_req; stray_ack injects an unsolicited ack.
    assign mem_ack   = (mem_req && (wait_cnt == wait_cfg)) || stray_ack;
    assign mem_rdata = mem_arr[mem_addr[9:2]];

    always @(posedge clk) begin
        if (!rst_n) begin
            mem_arr[24] <= 32'h0000_0000;
            mem_arr[25] <= 32'h1122_3344;
            mem_arr[26] <= 32'hCAFE_F00D;
            mem_arr[64] <= 32'h0050_0093;
        end else if (mem_req && mem_ack && mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b]) mem_arr[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
        if (!mem_req || mem_ack) wait_cnt <= 0;
        else                     wait_cnt <= wait_cnt + 1;
    end

    // Grant log: 1 = fetch (addresses >= 0x100), 0 = data.
    always @(negedge clk) begin
        if (rst_n && mem_req && !mem_req_prev) grants.push_back(mem_addr >= 32'h100);
        mem_req_prev <= mem_req;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dm_xfer(input string tag, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be);
        dm_req   = 1'b1;
        dm_we    = we;
        dm_addr  = addr;
        dm_wdata = wdata;
        dm_be    = be;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (dm_ready) break;
        end
        check_eq(tag, 32'(dm_ready), 32'd1);
        dm_req = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] pat;
        n_checks = 0;
        n_pass = 0;
        rst_n = 1'b0;
        if_req = 1'b0;
        if_addr = '0;
        dm_req = 1'b0;
        dm_we = 1'b0;
        dm_addr = '0;
        dm_wdata = '0;
        dm_be = '0;
        wait_cfg = 0;
        stray_ack = 1'b0;
        mem_req_prev = 1'b0;
        repeat (3) tick();

        // Reset state
        check_eq("rst_mem_req", 32'(mem_req), 32'd0);
        check_eq("rst_mem_we", 32'(mem_we), 32'd0);
        check_eq("rst_mem_addr", mem_addr, 32'd0);
        check_eq("rst_mem_be", 32'(mem_be), 32'd0);
        check_eq("rst_readies", {30'd0, if_ready, dm_ready}, 32'd0);
        check_eq("rst_rdata", if_rdata | dm_rdata, 32'd0);
        check_eq("rst_starve", 32'(dut.starve_cnt_q), 32'd0);
        rst_n = 1'b1;
        tick();

        // Solo fetch, zero-wait memory; low address bits are dropped
        if_req = 1'b1;
        if_addr = 32'h102;
        tick();
        check_eq("if_mem_req", 32'(mem_req), 32'd1);
        check_eq("if_mem_addr", mem_addr, 32'h100);
        check_eq("if_mem_we", 32'(mem_we), 32'd0);
        check_eq("if_mem_be", 32'(mem_be), 32'hF);
        check_eq("if_ready_early", 32'(if_ready), 32'd0);
        tick();
        check_eq("if_ready", 32'(if_ready), 32'd1);
        check_eq("if_rdata", if_rdata, 32'h0050_0093);
        check_eq("if_mem_req_drop", 32'(mem_req), 32'd0);
        if_req = 1'b0;
        tick();
        check_eq("if_ready_pulse", 32'(if_ready), 32'd0);

        // Solo data load
        dm_xfer("dm_load_ready", 1'b0, 32'h68, 32'h0, 4'hF);
        check_eq("dm_load_rdata", dm_rdata, 32'hCAFE_F00D);

        // Contention: store first, fetch in the IDLE cycle after the store's RESP
        if_req = 1'b1;
        if_addr = 32'h100;
        dm_req = 1'b1;
        dm_we = 1'b1;
        dm_addr = 32'h60;
        dm_wdata = 32'hDEAD_BEEF;
        dm_be = 4'hF;
        tick();
        check_eq("ct_first_addr", mem_addr, 32'h60);
        check_eq("ct_first_we", 32'(mem_we), 32'd1);
        check_eq("ct_first_wdata", mem_wdata, 32'hDEAD_BEEF);
        check_eq("ct_starve_inc", 32'(dut.starve_cnt_q), 32'd1);
        tick();
        check_eq("ct_dm_ready", 32'(dm_ready), 32'd1);
        dm_req = 1'b0;
        tick();
        check_eq("ct_idle_gap", 32'(mem_req), 32'd0);
        tick();
        check_eq("ct_if_grant", 32'(mem_req), 32'd1);
        check_eq("ct_if_addr", mem_addr, 32'h100);
        check_eq("ct_starve_clr", 32'(dut.starve_cnt_q), 32'd0);
        tick();
        check_eq("ct_if_ready", 32'(if_ready), 32'd1);
        if_req = 1'b0;
        tick();
        check_eq("ct_store_data", mem_arr[24], 32'hDEAD_BEEF);

        // Starvation: four data grants, then the fetch
        grants.delete();
        if_req = 1'b1;
        if_addr = 32'h100;
        dm_req = 1'b1;
        dm_we = 1'b0;
        dm_addr = 32'h68;
        dm_be = 4'hF;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (if_ready) break;
        end
        check_eq("sv_if_ready", 32'(if_ready), 32'd1);
        if_req = 1'b0;
        dm_req = 1'b0;
        pat = '0;
        foreach (grants[i]) pat = {pat[3:0], grants[i]};
        check_eq("sv_grant_count", grants.size(), 32'd5);
        check_eq("sv_grant_order", 32'(pat), 32'b00001);
        check_eq("sv_starve_cnt", 32'(dut.starve_cnt_q), 32'd0);
        tick();

        // Wait states: ack after 3 extra cycles
        wait_cfg = 3;
        dm_req = 1'b1;
        dm_we = 1'b0;
        dm_addr = 32'h60;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("ws_mem_req", 32'(mem_req), 32'd1);
            check_eq("ws_mem_addr", mem_addr, 32'h60);
            check_eq("ws_no_ready", 32'(dm_ready), 32'd0);
        end
        tick();
        check_eq("ws_ready", 32'(dm_ready), 32'd1);
        check_eq("ws_rdata", dm_rdata, 32'hDEAD_BEEF);
        dm_req = 1'b0;
        tick();
        check_eq("ws_ready_pulse", 32'(dm_ready), 32'd0);
        wait_cfg = 0;

        // Reset in the middle of a data access, then a stray ack
        wait_cfg = 10;
        dm_req = 1'b1;
        dm_addr = 32'h68;
        tick();
        tick();
        check_eq("rb_busy", 32'(dut.state_q), 32'(StDmBusy));
        #2;
        rst_n = 1'b0;
        dm_req = 1'b0;
        #1;
        check_eq("rb_mem_req", 32'(mem_req), 32'd0);
        check_eq("rb_dm_rdata", dm_rdata, 32'd0);
        wait_cfg = 0;
        tick();
        rst_n = 1'b1;
        tick();
        stray_ack = 1'b1;
        tick();
        stray_ack = 1'b0;
        check_eq("rb_stray_ready", {30'd0, if_ready, dm_ready}, 32'd0);
        check_eq("rb_stray_state", 32'(dut.state_q), 32'(StIdle));
        tick();
        check_eq("rb_stray_ready2", {30'd0, if_ready, dm_ready}, 32'd0);

        // Byte store must not touch dm_rdata
        dm_xfer("bs_preload_ready", 1'b0, 32'h68, 32'h0, 4'hF);
        dm_req = 1'b1;
        dm_we = 1'b1;
        dm_addr = 32'h64;
        dm_wdata = 32'hAABB_CCDD;
        dm_be = 4'b0100;
        tick();
        check_eq("bs_mem_be", 32'(mem_be), 32'b0100);
        check_eq("bs_mem_addr", mem_addr, 32'h64);
        check_eq("bs_mem_we", 32'(mem_we), 32'd1);
        tick();
        check_eq("bs_ready", 32'(dm_ready), 32'd1);
        check_eq("bs_dm_rdata", dm_rdata, 32'hCAFE_F00D);
        dm_req = 1'b0;
        tick();
        check_eq("bs_mem_word", mem_arr[25], 32'h11BB_3344);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: maximum consecutive data-port grants while an instruction request waits.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port if_req, input, 1: fetch request, a level held until if_ready.
REQ-005 SHALL have port if_addr, input, 32: fetch byte address; bits [1:0] are ignored.
REQ-006 SHALL have port if_rdata, output, 32: fetched word, valid while if_ready is high.
REQ-007 SHALL have port if_ready, output, 1: one-cycle completion pulse for the fetch request.
REQ-008 SHALL have port dm_req, input, 1: data request, a level held until dm_ready.
REQ-009 SHALL have ports dm_we (input, 1), dm_addr (input, 32), dm_wdata (input, 32) and dm_be (input, 4): write enable, address, write data and byte enables.
REQ-010 SHALL have ports dm_rdata (output, 32) and dm_ready (output, 1): load data and the one-cycle completion pulse.
REQ-011 SHALL have ports mem_req, mem_we, mem_addr[31:0], mem_wdata[31:0] and mem_be[3:0], all outputs and all registered, driving the unified single-port memory.
REQ-012 SHALL have ports mem_rdata (input, 32) and mem_ack (input, 1): the memory response; mem_ack is a one-cycle pulse.

Function
REQ-013 SHALL implement a state machine with states IDLE, IF_BUSY, DM_BUSY and RESP.
REQ-014 IDLE, no request pending: SHALL remain in IDLE with mem_req low.
REQ-015 IDLE, one request pending: SHALL grant that port and move to IF_BUSY or DM_BUSY, with mem_req and the port's signals registered on the same edge.
REQ-016 IDLE, both requests pending: SHALL grant the data port unless starve_cnt equals STARVE_LIMIT, in which case it SHALL grant the fetch port.
REQ-017 SHALL hold mem_req and all mem_* signals stable in the BUSY state until the cycle in which mem_ack is high.
REQ-018 mem_ack in a BUSY state: SHALL drop mem_req, capture mem_rdata into the granted port's rdata register and move to RESP.
REQ-019 RESP: SHALL assert the served port's ready for exactly one cycle, then return to IDLE.
REQ-020 Fetch accesses SHALL drive mem_we=0 and mem_be=4'hF.
REQ-021 Latency: a request sampled in IDLE at edge k gives mem_req high after edge k; mem_ack in cycle c gives ready in cycle c+1; minimum request-to-ready latency is 2 cycles.
REQ-022 Back-to-back: req still high in the first IDLE cycle after RESP SHALL be treated as a new transaction.
REQ-023 The rdata registers SHALL hold their last value; dm_rdata SHALL be updated only for dm_we=0 accesses.
REQ-024 starve_cnt (width clog2(STARVE_LIMIT+1)) SHALL increment on each data grant made while if_req is high, saturate at STARVE_LIMIT, and clear on every fetch grant.
REQ-025 mem_ack outside the BUSY states SHALL be ignored.
REQ-026 A requester dropping req before its ready is illegal; the arbiter SHALL complete the memory transaction anyway and SHALL flag the violation through a simulation assertion.

Reset
REQ-027 rst_n low SHALL immediately force: state=IDLE; mem_req, mem_we, if_ready, dm_ready=0; mem_addr, mem_wdata, if_rdata, dm_rdata=0; mem_be=0; starve_cnt=0.
REQ-028 Reset during BUSY SHALL abandon the transaction; a late mem_ack after reset release SHALL be ignored per REQ-025.

Structure
REQ-029 The arb_state_t enum and the DEFAULT_STARVE_LIMIT constant SHALL reside in the shared riscv_pkg package.
REQ-030 Grant selection SHALL be a combinational sub-module, mem_arb_pick (inputs if_req, dm_req, starve_hit; output one-hot grant); everything else SHALL be flat.

Verification
REQ-031 Solo fetch: if_req with if_addr=0x100, zero-wait memory returning 0x00500093 -> if_rdata=0x00500093 and if_ready in cycle 2; mem_we=0.
REQ-032 Contention: both req in the same cycle (dm store of 0xDEADBEEF to 0x60, be=4'hF) -> store granted first; fetch granted in the IDLE cycle after the store's RESP.
REQ-033 Starvation: dm_req held continuously with if_req pending, STARVE_LIMIT=4 -> exactly 4 data grants, then one fetch grant, then starve_cnt=0.
REQ-034 Wait states: mem_ack delayed 3 cycles -> mem_req and mem_addr held stable for 4 cycles; ready asserted exactly one cycle after mem_ack.
REQ-035 Reset mid-DM_BUSY: rst_n pulsed low -> mem_req=0 at once; a later stray mem_ack produces no ready pulse.
REQ-036 Byte store: dm_be=4'b0100 to address 0x64 -> mem_be=4'b0100 and mem_addr=0x64 with no read capture; dm_rdata unchanged.
